fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: the NOP bubble encoding and the
// instruction/PC+4 pair that travels from fetch into decode.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue between instruction memory and the F/D register.
// Storage only: push/pop/clear decisions are made by fetch_unit.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  fetch_entry_t           push_data,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign head    = mem[rd_ptr];

    // Entries are never read before being written, so the array needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order memory requests, queues responses,
// and feeds the F/D register, with redirect, stall and flush handling.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   branch_target;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] kill_count;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic          grant;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  push_entry;
    fetch_entry_t  fifo_head;

    assign branch_target = {PCBranchD[31:2], 2'b00};
    assign occupancy     = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req      = rst_n && !StallF && !PCSrcD && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign imem_addr     = fetch_pc;
    assign grant         = imem_req && imem_gnt;
    assign push          = imem_rvalid && (kill_count == '0) && !PCSrcD;
    assign pop           = !StallD && !FlushD && !PCSrcD && !fifo_empty;
    assign push_entry    = '{instr: imem_rdata, pcplus4: resp_pc + 32'd4};

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .clear     (PCSrcD),
        .push_data (push_entry),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // resp_pc tracks the address of the next live response, which is always
    // sequential from the most recent redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else if (PCSrcD) begin
            fetch_pc <= branch_target;
            resp_pc  <= branch_target;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            kill_count  <= '0;
        end else begin
            case ({grant, imem_rvalid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            if (PCSrcD) begin
                kill_count <= outstanding - (imem_rvalid ? CW'(1) : CW'(0));
            end else if (imem_rvalid && (kill_count != '0)) begin
                kill_count <= kill_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (PCSrcD || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (!fifo_empty) begin
                InstrD   <= fifo_head.instr;
                PCPlus4D <= fifo_head.pcplus4;
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= NOP_INSTR;
                PCPlus4D <= '0;
                ValidD   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order memory model with random
// grant/latency plus a queue-based reference of the fetch/decode behaviour.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        PCSrcD = 1'b0;
    logic [31:0] PCBranchD = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .PCSrcD      (PCSrcD),
        .PCBranchD   (PCBranchD),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .InstrD      (InstrD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: fetch PC, queued fetch results, decode register.
    logic [31:0] m_pc;
    logic [31:0] fq_instr [$];
    logic [31:0] fq_pc4 [$];
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;

    // Memory side: granted addresses in order, with staleness and timing.
    logic [31:0] mq_addr [$];
    bit          mq_stale [$];
    int          mq_age [$];
    int          mq_lat [$];

    logic        samp_req;
    logic [31:0] samp_addr;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("InstrD", InstrD, m_instr);
        checkVal("PCPlus4D", PCPlus4D, m_pc4);
        checkVal("ValidD", {31'b0, ValidD}, {31'b0, m_valid});
    endtask

    task automatic modelBubble();
        m_instr = NOP_INSTR;
        m_pc4   = '0;
        m_valid = 1'b0;
    endtask

    task automatic modelReset();
        m_pc = RESET_PC;
        fq_instr.delete();
        fq_pc4.delete();
        mq_addr.delete();
        mq_stale.delete();
        mq_age.delete();
        mq_lat.delete();
        modelBubble();
    endtask

    // One clock cycle: drive inputs at negedge, check, advance the model.
    task automatic applyStimulus(input bit sf, input bit sd, input bit fd, input bit br,
                                 input logic [31:0] tgt, input bit gnt, input int lat);
        bit          rv;
        bit          st;
        bit          exp_req;
        logic [31:0] ra;
        int          dummy;
        @(negedge clk);
        checkOutput();
        StallF    = sf;
        StallD    = sd;
        FlushD    = fd;
        PCSrcD    = br;
        PCBranchD = tgt;
        imem_gnt  = gnt;
        rv = (mq_addr.size() > 0) && (mq_age[0] >= mq_lat[0]);
        imem_rvalid = rv;
        imem_rdata  = rv ? mq_addr[0] : 32'hDEAD_BEEF;
        exp_req = !sf && !br && ((fq_instr.size() + mq_addr.size()) < DEPTH);
        #1;
        samp_req  = imem_req;
        samp_addr = imem_addr;
        checkVal("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) checkVal("imem_addr", imem_addr, m_pc);
        st = 1'b0;
        ra = '0;
        if (rv) begin
            ra    = mq_addr.pop_front();
            st    = mq_stale.pop_front();
            dummy = mq_age.pop_front();
            dummy = mq_lat.pop_front();
        end
        for (int i = 0; i < mq_age.size(); i++) mq_age[i] = mq_age[i] + 1;
        if (br) begin
            for (int i = 0; i < mq_stale.size(); i++) mq_stale[i] = 1'b1;
            fq_instr.delete();
            fq_pc4.delete();
            modelBubble();
            m_pc = {tgt[31:2], 2'b00};
        end else begin
            if (fd) begin
                modelBubble();
            end else if (!sd) begin
                if (fq_instr.size() > 0) begin
                    m_instr = fq_instr.pop_front();
                    m_pc4   = fq_pc4.pop_front();
                    m_valid = 1'b1;
                end else begin
                    modelBubble();
                end
            end
            if (rv && !st) begin
                fq_instr.push_back(ra);
                fq_pc4.push_back(ra + 32'd4);
            end
            if (exp_req && gnt) begin
                mq_addr.push_back(m_pc);
                mq_stale.push_back(1'b0);
                mq_age.push_back(1);
                mq_lat.push_back(lat);
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input bit midcycle);
        if (midcycle) begin
            @(negedge clk);
            #2;
        end
        rst_n       = 1'b0;
        StallF      = 1'b0;
        StallD      = 1'b0;
        FlushD      = 1'b0;
        PCSrcD      = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        checkVal("rst InstrD", InstrD, 32'h0000_0013);
        checkVal("rst PCPlus4D", PCPlus4D, 32'h0);
        checkVal("rst ValidD", {31'b0, ValidD}, 32'h0);
        checkVal("rst imem_req", {31'b0, imem_req}, 32'h0);
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("post-rst imem_req", {31'b0, imem_req}, 32'h1);
        checkVal("post-rst imem_addr", imem_addr, RESET_PC);
    endtask

    initial begin
        bit found;
        doReset(1'b0);

        // Sequential fetch with a grant stall holding the address.
        applyStimulus(0, 0, 0, 0, '0, 1, 1);
        checkVal("first addr", samp_addr, 32'h0);
        applyStimulus(0, 0, 0, 0, '0, 1, 1);
        checkVal("second addr", samp_addr, 32'h4);
        applyStimulus(0, 0, 0, 0, '0, 1, 1);
        checkVal("first ValidD", {31'b0, ValidD}, 32'h1);
        checkVal("first InstrD", InstrD, 32'h0);
        checkVal("first PCPlus4D", PCPlus4D, 32'h4);
        repeat (3) begin
            applyStimulus(0, 0, 0, 0, '0, 0, 1);
            checkVal("held req", {31'b0, samp_req}, 32'h1);
            checkVal("held addr", samp_addr, 32'h8);
        end
        applyStimulus(0, 0, 0, 0, '0, 1, 1);
        checkVal("granted addr", samp_addr, 32'h8);
        repeat (4) applyStimulus(0, 0, 0, 0, '0, 1, 1);

        // Redirect with two requests in flight.
        doReset(1'b1);
        applyStimulus(0, 0, 0, 0, '0, 1, 3);
        applyStimulus(0, 0, 0, 0, '0, 1, 3);
        applyStimulus(0, 0, 0, 1, 32'h0000_0102, 1, 1);
        checkVal("redir ValidD", {31'b0, ValidD}, 32'h0);
        checkVal("redir InstrD", InstrD, 32'h0000_0013);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(0, 0, 0, 0, '0, 1, 1);
            if (samp_req) begin
                found = 1'b1;
                checkVal("redir first addr", samp_addr, 32'h0000_0100);
            end
        end
        if (!found) checkVal("redir req timeout", 32'h0, 32'h1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(0, 0, 0, 0, '0, 1, 1);
            if (ValidD) begin
                found = 1'b1;
                checkVal("redir PCPlus4D", PCPlus4D, 32'h0000_0104);
                checkVal("redir InstrD val", InstrD, 32'h0000_0100);
            end
        end
        if (!found) checkVal("redir valid timeout", 32'h0, 32'h1);

        // Decode stall fills the queue, then a one-cycle flush.
        repeat (4) applyStimulus(0, 1, 0, 0, '0, 1, 1);
        checkVal("stall req drop", {31'b0, samp_req}, 32'h0);
        applyStimulus(0, 0, 1, 0, '0, 1, 1);
        checkVal("flush ValidD", {31'b0, ValidD}, 32'h0);
        repeat (6) applyStimulus(0, 0, 0, 0, '0, 1, 1);

        // Randomised traffic with a mid-run reset.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) doReset(1'b1);
            applyStimulus(($urandom_range(99) < 20), ($urandom_range(99) < 25),
                          ($urandom_range(99) < 10), ($urandom_range(99) < 6),
                          $urandom(), ($urandom_range(99) < 75), $urandom_range(3, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
